// File: rtl/nco_spi_pkg.sv
// Shared constants and FSM state type for the NCO tuning-word SPI register file.
package nco_spi_pkg;

   localparam int unsigned CMD_RW_BIT     = 7;
   localparam logic [6:0]  BROADCAST_ADDR = 7'h7F;
   localparam int unsigned CMD_BITS       = 8;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA,
      DONE
   } state_t;

endpackage

// File: rtl/nco_spi_regfile_if.sv
// SPI pin bundle between an external master and the tuning-word register file.
interface nco_spi_regfile_if;
   logic i_SCLK;
   logic i_CS;
   logic i_MOSI;
   logic o_MISO;

   modport master (output i_SCLK, output i_CS, output i_MOSI, input o_MISO);
   modport slave  (input i_SCLK, input i_CS, input i_MOSI, output o_MISO);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, with one-cycle rise/fall pulses.
module spi_sync_edge #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
         r_prev <= RESET_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_prev;
   assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/nco_spi_regfile.sv
// SPI slave holding NUM_CHANNELS double-buffered NCO tuning words; writes commit on CS rise
// only after a correctly sized frame.
module nco_spi_regfile
   import nco_spi_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned DATA_WIDTH   = 32
) (
   input  logic                               i_clock,
   input  logic                               i_reset,
   nco_spi_regfile_if.slave                   io_spi,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_tuning_words,
   output logic [NUM_CHANNELS-1:0]            o_update,
   output logic                               o_frame_error
);

   localparam int unsigned FRAME_BITS = CMD_BITS + DATA_WIDTH;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_CMD_BIT = CNT_W'(CMD_BITS - 1);
   localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(FRAME_BITS - 1);

   logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;
   logic w_unused_sclk_level, w_unused_cs_level, w_unused_mosi_rise, w_unused_mosi_fall;
   logic [CMD_BITS-1:0] w_cmd_next;
   logic                w_addr_valid;

   state_t                r_state;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [CMD_BITS-2:0]   r_cmd;
   logic [DATA_WIDTH-1:0] r_rx;
   logic [DATA_WIDTH-1:0] r_tx;
   logic                  r_is_read;
   logic [6:0]            r_addr;
   logic                  r_long;
   logic                  r_miso;
   logic [DATA_WIDTH-1:0] r_words [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] r_update;
   logic                  r_frame_error;

   spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_async (io_spi.i_SCLK),
      .o_level (w_unused_sclk_level),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   // CS resets high so an idle bus does not look like a frame start.
   spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_async (io_spi.i_CS),
      .o_level (w_unused_cs_level),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_async (io_spi.i_MOSI),
      .o_level (w_mosi),
      .o_rise  (w_unused_mosi_rise),
      .o_fall  (w_unused_mosi_fall)
   );

   assign w_cmd_next   = {r_cmd, w_mosi};
   assign w_addr_valid = 32'(r_addr) < NUM_CHANNELS;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= IDLE;
         r_bit_cnt     <= '0;
         r_cmd         <= '0;
         r_rx          <= '0;
         r_tx          <= '0;
         r_is_read     <= 1'b0;
         r_addr        <= '0;
         r_long        <= 1'b0;
         r_miso        <= 1'b0;
         r_update      <= '0;
         r_frame_error <= 1'b0;
         for (int i = 0; i < NUM_CHANNELS; i++) r_words[i] <= '0;
      end else begin
         r_update      <= '0;
         r_frame_error <= 1'b0;
         if (w_cs_fall) begin
            r_state   <= CMD;
            r_bit_cnt <= '0;
            r_cmd     <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_is_read <= 1'b0;
            r_addr    <= '0;
            r_long    <= 1'b0;
            r_miso    <= 1'b0;
         end else if (w_cs_rise) begin
            r_state <= IDLE;
            r_miso  <= 1'b0;
            case (r_state)
               CMD, DATA: r_frame_error <= 1'b1;
               DONE: begin
                  if (r_long || (r_is_read && r_addr == BROADCAST_ADDR)) begin
                     r_frame_error <= 1'b1;
                  end else if (!r_is_read) begin
                     if (r_addr == BROADCAST_ADDR) begin
                        for (int i = 0; i < NUM_CHANNELS; i++) r_words[i] <= r_rx;
                        r_update <= '1;
                     end else if (w_addr_valid) begin
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                           if (r_addr == 7'(i)) begin
                              r_words[i]  <= r_rx;
                              r_update[i] <= 1'b1;
                           end
                        end
                     end else begin
                        r_frame_error <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end else begin
            if (w_sclk_rise) begin
               case (r_state)
                  CMD: begin
                     r_cmd     <= w_cmd_next[CMD_BITS-2:0];
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt == LAST_CMD_BIT) begin
                        r_state   <= DATA;
                        r_is_read <= w_cmd_next[CMD_RW_BIT];
                        r_addr    <= w_cmd_next[6:0];
                        // Snapshot the word now so a concurrent commit cannot tear a read.
                        r_tx <= '0;
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                           if (w_cmd_next[6:0] == 7'(i)) r_tx <= r_words[i];
                        end
                     end
                  end
                  DATA: begin
                     r_rx      <= {r_rx[DATA_WIDTH-2:0], w_mosi};
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt == LAST_BIT) r_state <= DONE;
                  end
                  DONE: r_long <= 1'b1;
                  default: ;
               endcase
            end
            if (w_sclk_fall && r_state == DATA && r_is_read) begin
               r_miso <= r_tx[DATA_WIDTH-1];
               r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_words
      assign o_tuning_words[g*DATA_WIDTH +: DATA_WIDTH] = r_words[g];
   end

   assign o_update      = r_update;
   assign o_frame_error = r_frame_error;
   assign io_spi.o_MISO = r_miso;

endmodule

// File: tb/tb_nco_spi_regfile.sv
// Randomised self-checking bench for nco_spi_regfile against a word-level register model.
module tb_nco_spi_regfile;

   localparam int unsigned N    = 4;
   localparam int unsigned DW   = 32;
   localparam int unsigned FULL = 8 + DW;
   localparam int          HALF = 40;

   logic            i_clock = 1'b0;
   logic            i_reset;
   logic [N*DW-1:0] o_tuning_words;
   logic [N-1:0]    o_update;
   logic            o_frame_error;

   nco_spi_regfile_if spi_if ();

   nco_spi_regfile #(
      .NUM_CHANNELS (N),
      .DATA_WIDTH   (DW)
   ) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .io_spi         (spi_if),
      .o_tuning_words (o_tuning_words),
      .o_update       (o_update),
      .o_frame_error  (o_frame_error)
   );

   always #5 i_clock = ~i_clock;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0]   m_words [N];
   logic [DW-1:0]   g_miso;
   logic            g_cmd_miso;
   logic [N-1:0]    g_upd_or;
   int              g_upd_hi, g_err_hi, g_lat;
   logic [N*DW-1:0] g_words_at_evt;

   logic [N-1:0]    e_upd;
   logic            e_err;
   logic [DW-1:0]   e_miso;

   function automatic logic [N*DW-1:0] pack_model();
      logic [N*DW-1:0] p;
      for (int i = 0; i < N; i++) p[i*DW +: DW] = m_words[i];
      return p;
   endfunction

   // Register-level meaning of one frame: what gets committed, flagged or read back.
   task automatic model_frame(input logic [7:0] cmd, input logic [DW-1:0] data, input int total);
      int a;
      a      = int'(cmd[6:0]);
      e_upd  = '0;
      e_err  = 1'b0;
      e_miso = '0;
      if (total != FULL) e_err = 1'b1;
      else if (cmd[7]) begin
         if (a == 127) e_err = 1'b1;
         else if (a < N) e_miso = m_words[a];
      end else if (a == 127) begin
         for (int i = 0; i < N; i++) m_words[i] = data;
         e_upd = '1;
      end else if (a < N) begin
         m_words[a] = data;
         e_upd[a]   = 1'b1;
      end else e_err = 1'b1;
   endtask

   task automatic spi_bits(input logic [7:0] cmd, input logic [DW-1:0] data, input int total);
      g_miso     = '0;
      g_cmd_miso = 1'b0;
      spi_if.i_CS = 1'b0;
      #HALF;
      for (int i = 0; i < total; i++) begin
         if (i < 8) spi_if.i_MOSI = cmd[7-i];
         else if (i < FULL) spi_if.i_MOSI = data[DW-1-(i-8)];
         else spi_if.i_MOSI = 1'($urandom);
         #HALF;
         if (i < 8) g_cmd_miso = g_cmd_miso | spi_if.o_MISO;
         else if (i < FULL) g_miso = {g_miso[DW-2:0], spi_if.o_MISO};
         spi_if.i_SCLK = 1'b1;
         #HALF;
         spi_if.i_SCLK = 1'b0;
      end
      #HALF;
   endtask

   task automatic observe(input int ncyc);
      g_upd_or = '0;
      g_upd_hi = 0;
      g_err_hi = 0;
      g_lat    = 0;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge i_clock);
         if ((o_update != '0 || o_frame_error) && g_lat == 0) begin
            g_lat          = k;
            g_words_at_evt = o_tuning_words;
         end
         g_upd_or = g_upd_or | o_update;
         if (o_update != '0) g_upd_hi++;
         if (o_frame_error) g_err_hi++;
      end
   endtask

   task automatic spi_frame(input logic [7:0] cmd, input logic [DW-1:0] data, input int total,
                            input int gap);
      spi_bits(cmd, data, total);
      @(posedge i_clock);
      #2;
      spi_if.i_CS = 1'b1;
      observe(gap);
   endtask

   task automatic test_reset();
      spi_if.i_CS   = 1'b1;
      spi_if.i_SCLK = 1'b0;
      spi_if.i_MOSI = 1'b0;
      i_reset = 1'b1;
      for (int i = 0; i < N; i++) m_words[i] = '0;
      repeat (4) @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b0;
      repeat (3) @(negedge i_clock);
      checks++;
      if (o_tuning_words !== '0) begin
         errors++; $display("FAIL reset_words got %h want 0", o_tuning_words);
      end
      checks++;
      if (o_update !== '0) begin errors++; $display("FAIL reset_update got %b want 0", o_update); end
      checks++;
      if (o_frame_error !== 1'b0) begin
         errors++; $display("FAIL reset_error got %b want 0", o_frame_error);
      end
      checks++;
      if (spi_if.o_MISO !== 1'b0) begin
         errors++; $display("FAIL reset_miso got %b want 0", spi_if.o_MISO);
      end
   endtask

   task automatic test_write_single();
      model_frame(8'h02, 32'hDEADBEEF, FULL);
      spi_frame(8'h02, 32'hDEADBEEF, FULL, 8);
      checks++;
      if (o_tuning_words !== pack_model()) begin
         errors++; $display("FAIL write2_words got %h want %h", o_tuning_words, pack_model());
      end
      checks++;
      if (g_upd_or !== 4'b0100) begin errors++; $display("FAIL write2_update got %b want 0100", g_upd_or); end
      checks++;
      if (g_upd_hi != 1) begin errors++; $display("FAIL write2_pulse_len got %0d want 1", g_upd_hi); end
      checks++;
      if (g_err_hi != 0) begin errors++; $display("FAIL write2_error got %0d want 0", g_err_hi); end
      checks++;
      if (g_lat < 3 || g_lat > 4) begin errors++; $display("FAIL write2_latency got %0d want 3..4", g_lat); end
      checks++;
      if (g_words_at_evt !== pack_model()) begin
         errors++; $display("FAIL write2_words_with_update got %h want %h", g_words_at_evt, pack_model());
      end
   endtask

   task automatic test_read_back();
      model_frame(8'h01, 32'h12345678, FULL);
      spi_frame(8'h01, 32'h12345678, FULL, 8);
      checks++;
      if (g_upd_or !== 4'b0010) begin errors++; $display("FAIL write1_update got %b want 0010", g_upd_or); end
      model_frame(8'h81, 32'h0, FULL);
      spi_frame(8'h81, DW'($urandom), FULL, 8);
      checks++;
      if (g_miso !== 32'h12345678) begin errors++; $display("FAIL read1_data got %h want 12345678", g_miso); end
      checks++;
      if (g_cmd_miso !== 1'b0) begin errors++; $display("FAIL read1_cmd_miso got %b want 0", g_cmd_miso); end
      checks++;
      if (g_upd_or !== '0 || g_err_hi != 0) begin
         errors++; $display("FAIL read1_side_effects got upd %b err %0d want 0 0", g_upd_or, g_err_hi);
      end
      checks++;
      if (o_tuning_words !== pack_model()) begin
         errors++; $display("FAIL read1_words got %h want %h", o_tuning_words, pack_model());
      end
   endtask

   task automatic test_broadcast();
      model_frame(8'h7F, 32'hA5A5A5A5, FULL);
      spi_frame(8'h7F, 32'hA5A5A5A5, FULL, 8);
      checks++;
      if (o_tuning_words !== {N{32'hA5A5A5A5}}) begin
         errors++; $display("FAIL bcast_words got %h want all A5A5A5A5", o_tuning_words);
      end
      checks++;
      if (g_upd_or !== 4'b1111 || g_upd_hi != 1) begin
         errors++; $display("FAIL bcast_update got %b x%0d want 1111 x1", g_upd_or, g_upd_hi);
      end
   endtask

   task automatic test_bad_length();
      int lens [2];
      lens[0] = 8 + 20;
      lens[1] = 8 + 33;
      for (int j = 0; j < 2; j++) begin
         model_frame(8'h00, 32'h0BADF00D, lens[j]);
         spi_frame(8'h00, 32'h0BADF00D, lens[j], 8);
         checks++;
         if (g_err_hi != 1 || g_upd_or !== '0) begin
            errors++; $display("FAIL badlen%0d_flags got err %0d upd %b want 1 0", lens[j] - 8, g_err_hi, g_upd_or);
         end
         checks++;
         if (g_lat < 3 || g_lat > 4) begin
            errors++; $display("FAIL badlen%0d_latency got %0d want 3..4", lens[j] - 8, g_lat);
         end
         checks++;
         if (o_tuning_words !== pack_model()) begin
            errors++; $display("FAIL badlen%0d_words got %h want %h", lens[j] - 8, o_tuning_words, pack_model());
         end
      end
   endtask

   task automatic test_invalid_addr();
      model_frame(8'h05, 32'h55667788, FULL);
      spi_frame(8'h05, 32'h55667788, FULL, 8);
      checks++;
      if (g_err_hi != 1 || g_upd_or !== '0) begin
         errors++; $display("FAIL wr_addr5 got err %0d upd %b want 1 0", g_err_hi, g_upd_or);
      end
      checks++;
      if (o_tuning_words !== pack_model()) begin
         errors++; $display("FAIL wr_addr5_words got %h want %h", o_tuning_words, pack_model());
      end
      spi_frame(8'h85, DW'($urandom), FULL, 8);
      checks++;
      if (g_miso !== '0 || g_err_hi != 0) begin
         errors++; $display("FAIL rd_addr5 got miso %h err %0d want 0 0", g_miso, g_err_hi);
      end
   endtask

   task automatic test_reset_mid_frame();
      spi_bits(8'h03, 32'hFEEDFACE, 8 + 12);
      i_reset = 1'b1;
      for (int i = 0; i < N; i++) m_words[i] = '0;
      #30;
      spi_if.i_CS = 1'b1;
      #30;
      @(negedge i_clock);
      i_reset = 1'b0;
      observe(8);
      checks++;
      if (o_tuning_words !== '0 || g_upd_or !== '0 || g_err_hi != 0) begin
         errors++; $display("FAIL midreset got words %h upd %b err %0d want 0 0 0",
                            o_tuning_words, g_upd_or, g_err_hi);
      end
      model_frame(8'h03, 32'hCAFEF00D, FULL);
      spi_frame(8'h03, 32'hCAFEF00D, FULL, 8);
      checks++;
      if (o_tuning_words !== pack_model() || g_upd_or !== 4'b1000) begin
         errors++; $display("FAIL after_reset_write got %h upd %b want %h 1000",
                            o_tuning_words, g_upd_or, pack_model());
      end
   endtask

   // Tight CS-high gaps; each frame must stand on its own.
   task automatic test_random_back_to_back();
      logic [7:0]  cmd;
      logic [DW-1:0] data;
      int          total;
      for (int n = 0; n < 40; n++) begin
         case ($urandom % 6)
            0:       cmd = {1'b0, 7'($urandom % N)};
            1:       cmd = {1'b1, 7'($urandom % N)};
            2:       cmd = 8'h7F;
            3:       cmd = 8'hFF;
            4:       cmd = {1'b0, 7'($urandom_range(N, 126))};
            default: cmd = {1'b1, 7'($urandom_range(N, 126))};
         endcase
         data  = DW'($urandom);
         total = ($urandom % 4 == 0) ? int'($urandom_range(0, FULL + 3)) : FULL;
         model_frame(cmd, data, total);
         spi_frame(cmd, data, total, 5);
         checks++;
         if (g_upd_or !== e_upd || g_upd_hi != ((e_upd != '0) ? 1 : 0)) begin
            errors++; $display("FAIL rand%0d_update cmd %h len %0d got %b x%0d want %b",
                               n, cmd, total, g_upd_or, g_upd_hi, e_upd);
         end
         checks++;
         if (g_err_hi != int'(e_err)) begin
            errors++; $display("FAIL rand%0d_error cmd %h len %0d got %0d want %0d",
                               n, cmd, total, g_err_hi, e_err);
         end
         checks++;
         if (o_tuning_words !== pack_model()) begin
            errors++; $display("FAIL rand%0d_words cmd %h got %h want %h", n, cmd, o_tuning_words,
                               pack_model());
         end
         if (cmd[7] && total == FULL) begin
            checks++;
            if (g_miso !== e_miso) begin
               errors++; $display("FAIL rand%0d_miso cmd %h got %h want %h", n, cmd, g_miso, e_miso);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_single();
      test_read_back();
      test_broadcast();
      test_bad_length();
      test_invalid_addr();
      test_reset_mid_frame();
      test_random_back_to_back();
      checks++;
      if (spi_if.o_MISO !== 1'b0) begin
         errors++; $display("FAIL idle_miso got %b want 0", spi_if.o_MISO);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/nco_spi_regfile.md
# nco_spi_regfile

Parametrised multi-channel SPI slave that loads tuning words for a bank of NCOs. An SPI master writes or reads one channel's DATA_WIDTH-bit word per frame, selected by an address byte. Writes are double-buffered and committed only on CS deassertion after a correctly sized frame, so NCO phase accumulators never see partial words. It sits between the external SPI pins and the NCO bank, entirely in the i_clock domain.

## Interface
- NUM_CHANNELS, 4, number of tuning-word registers (1..126)
- DATA_WIDTH, 32, bits per tuning word (8..64)
- i_clock  in  1  system clock; one clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_SCLK  in  1  SPI clock, asynchronous to i_clock, mode 0
- i_CS  in  1  SPI chip select, active-low, asynchronous
- i_MOSI  in  1  SPI data in, MSB first
- o_MISO  out  1  SPI data out, MSB first
- o_tuning_words  out  NUM_CHANNELS*DATA_WIDTH  committed words, channel 0 in LSBs
- o_update  out  NUM_CHANNELS  one-cycle pulse per channel on commit
- o_frame_error  out  1  one-cycle pulse on rejected frame

## Operation
- SCLK, CS, MOSI pass through 2-flop synchronisers; edges detected in i_clock domain. Requires f(i_clock) >= 4x f(SCLK).
- Frame: command byte then DATA_WIDTH data bits, 8+DATA_WIDTH SCLK rising edges total. MOSI sampled on SCLK rise; MISO updated on SCLK fall.
- Command byte: bit 7 = 1 read / 0 write; bits 6:0 = address. Address 0x7F = broadcast (write only).
- FSM: IDLE -> CMD on CS fall; CMD -> DATA after 8th sampled bit (command decoded); DATA -> DONE after DATA_WIDTH bits; any state -> IDLE on CS rise.
- Write commit: CS rise in DONE with valid address -> shift register copied to addressed word (all words for 0x7F); matching o_update bit(s) pulse.
- Read: on SCLK fall after the command byte, o_MISO presents the addressed committed word MSB first; shift continues each SCLK fall. No commit, no o_update.
- o_MISO = 0 during command phase, while CS high, and for read of invalid address.
- Errors (pulse o_frame_error, no commit): CS rise in CMD or DATA (short frame); SCLK rise in DONE (long frame, remainder ignored, error on CS rise); write to address >= NUM_CHANNELS other than 0x7F; read of 0x7F.
- CS fall while not IDLE (impossible after sync) treated as new frame start.

## Timing
- Reset: o_tuning_words all 0, o_update 0, o_frame_error 0, o_MISO 0, FSM IDLE, shift register 0. Reset mid-frame discards frame, no commit.
- Commit latency: o_tuning_words and o_update change on the 3rd i_clock rising edge after the CS pin rise (+1 cycle synchroniser tolerance). o_update high exactly 1 cycle, same cycle words change.
- o_frame_error same latency as commit, 1 cycle.
- o_MISO valid within 3 i_clock cycles after SCLK fall.
- Back-to-back frames: CS high >= 2 i_clock cycles between frames; second frame fully independent.
- Committed words hold value indefinitely between commits.

## Structure
- Package nco_spi_pkg: CMD_RW_BIT=7, BROADCAST_ADDR=7'h7F, CMD_BITS=8, FSM state enum (IDLE, CMD, DATA, DONE).
- Sub-module spi_sync_edge: 2-flop synchroniser plus rise/fall pulses; instantiated for SCLK, CS, MOSI (MOSI uses level only).
- Top holds FSM, bit counter (width clog2(8+DATA_WIDTH+1)), shift registers, word array.

## Test plan
- Reset, write 0x02 + 0xDEADBEEF -> only word 2 = 0xDEADBEEF, o_update = 4'b0100 for 1 cycle, others 0.
- Write ch1 = 0x12345678, then read 0x81 -> MISO returns 0x12345678 MSB first, no o_update, no error.
- Broadcast write 0x7F + 0xA5A5A5A5 -> all four words 0xA5A5A5A5, o_update = 4'b1111 one cycle.
- Write ch0 with CS raised after 20 data bits -> o_frame_error pulse, word 0 unchanged; repeat with 33 data bits -> same.
- Write address 0x05 (NUM_CHANNELS=4) -> o_frame_error pulse, no word changes; read 0x85 -> MISO all 0.
- Assert i_reset mid data phase of write to ch3 -> all words 0, no o_update; next full frame commits normally.
